// File: rtl/pio_pkg.sv
// Shared definitions for the PIO slaves: register addresses and edge-type encodings.
package pio_pkg;

   typedef logic [1:0] pio_addr_t;

   // Register map
   localparam pio_addr_t ADDR_DATA    = 2'd0;
   localparam pio_addr_t ADDR_IRQMASK = 2'd2;
   localparam pio_addr_t ADDR_EDGECAP = 2'd3;

   // Capture edge select
   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchronizer followed by an optional debounce filter.
// Macro PIO_IN_DEBOUNCE_EN: defined -> counter-based debounce; undefined -> filt follows sync2.
module pio_debounce_bit
`ifdef PIO_IN_DEBOUNCE_EN
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
)
`endif
(
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic filt
);

   logic sync1_q;
   logic sync2_q;

   // Two-flop synchronizer for the asynchronous pin
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
      end
   end

`ifdef PIO_IN_DEBOUNCE_EN
   localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   // Accept a new level only after it has differed from filt for DEBOUNCE_CYCLES edges
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         filt  <= 1'b0;
      end else if (sync2_q != filt) begin
         if (cnt_q == CNT_LAST) begin
            filt  <= sync2_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_q <= '0;
      end
   end
`else
   // No filtering: one register stage after the synchronizer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt <= 1'b0;
      end else begin
         filt <= sync2_q;
      end
   end
`endif

endmodule

// File: rtl/nios_system_pio_in.sv
// Avalon-MM input PIO: synchronized/debounced inputs, edge capture, masked level interrupt.
// Debounce is enabled by defining PIO_IN_DEBOUNCE_EN.
module nios_system_pio_in
   import pio_pkg::*;
#(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned EDGE_TYPE       = 0,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   if (WIDTH < 1 || WIDTH > 32 || EDGE_TYPE > EDGE_ANY || DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
      $error("nios_system_pio_in: parameter out of range");
   end

   logic [WIDTH-1:0] filt;
   logic [WIDTH-1:0] filt_d_q;
   logic [WIDTH-1:0] irq_mask_q;
   logic [WIDTH-1:0] edge_cap_q;
   logic [WIDTH-1:0] edge_pulse;
   logic [WIDTH-1:0] cap_clr;
   logic             wr_en;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
`ifdef PIO_IN_DEBOUNCE_EN
      pio_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
         .clk    (clk),
         .reset_n(reset_n),
         .din    (in_port[g]),
         .filt   (filt[g])
      );
`else
      pio_debounce_bit u_bit (
         .clk    (clk),
         .reset_n(reset_n),
         .din    (in_port[g]),
         .filt   (filt[g])
      );
`endif
   end

   if (WIDTH < 32) begin : g_wdata_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
   end

   assign wr_en   = chipselect & ~write_n;
   assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

   // Edge pulse from the filtered level and its one-cycle delayed copy
   always_comb begin
      edge_pulse = '0;
      case (EDGE_TYPE)
         EDGE_RISE: edge_pulse = filt & ~filt_d_q;
         EDGE_FALL: edge_pulse = ~filt & filt_d_q;
         EDGE_ANY:  edge_pulse = filt ^ filt_d_q;
         default:   edge_pulse = '0;
      endcase
   end

   // Delay line, mask register and edge capture (a set beats a same-cycle clear)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_d_q   <= '0;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
      end else begin
         filt_d_q   <= filt;
         edge_cap_q <= (edge_cap_q & ~cap_clr) | edge_pulse;
         if (wr_en && address == ADDR_IRQMASK) begin
            irq_mask_q <= writedata[WIDTH-1:0];
         end
      end
   end

   assign irq = |(edge_cap_q & irq_mask_q);

   // Zero-wait-state read mux
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:    readdata[WIDTH-1:0] = filt;
         ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask_q;
         ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap_q;
         default:      readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_nios_system_pio_in.sv
// Bench for nios_system_pio_in: rise/fall/any instances on a shared bus, checked every cycle
// against a vector-level behavioural model.
module tb_nios_system_pio_in;

`ifdef PIO_IN_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif
   localparam int DC       = 16;
   localparam int LAT_FILT = DEB ? DC + 2 : 3;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic [1:0]  address    = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n    = 1'b1;
   logic [31:0] writedata  = 32'd0;
   logic [7:0]  in_port    = 8'd0;
   logic [31:0] rd [3];
   logic        irq_w [3];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nios_system_pio_in #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DC)) u_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd[0]), .irq(irq_w[0]));
   nios_system_pio_in #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DC)) u_fall (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd[1]), .irq(irq_w[1]));
   nios_system_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DC)) u_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd[2]), .irq(irq_w[2]));

   // Behavioural model state
   logic [7:0] m_s1, m_s2, m_filt, m_filtd, m_mask;
   logic [7:0] m_cap [3];
   int         m_run [8];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] pulse(input int e, input logic [7:0] f, input logic [7:0] fd);
      case (e)
         0:       return f & ~fd;
         1:       return ~f & fd;
         default: return f ^ fd;
      endcase
   endfunction

   function automatic logic [31:0] exp_rd(input int e, input logic [1:0] a);
      case (a)
         2'd0:    return {24'd0, m_filt};
         2'd2:    return {24'd0, m_mask};
         2'd3:    return {24'd0, m_cap[e]};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_filt = '0; m_filtd = '0; m_mask = '0;
      for (int e = 0; e < 3; e++) m_cap[e] = '0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied
   task automatic model_edge();
      logic       wr;
      logic [7:0] clr;
      wr  = chipselect && !write_n;
      clr = (wr && address == 2'd3) ? writedata[7:0] : 8'd0;
      for (int e = 0; e < 3; e++) m_cap[e] = (m_cap[e] & ~clr) | pulse(e, m_filt, m_filtd);
      if (wr && address == 2'd2) m_mask = writedata[7:0];
      m_filtd = m_filt;
      if (DEB) begin
         for (int i = 0; i < 8; i++) begin
            if (m_s2[i] != m_filt[i]) begin
               m_run[i]++;
               if (m_run[i] == DC) begin
                  m_filt[i] = m_s2[i];
                  m_run[i]  = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end else begin
         m_filt = m_s2;
      end
      m_s2 = m_s1;
      m_s1 = in_port;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      for (int e = 0; e < 3; e++) begin
         check_eq($sformatf("irq%0d", e), {31'd0, irq_w[e]}, {31'd0, |(m_cap[e] & m_mask)});
         check_eq($sformatf("rd%0d_a%0d", e, address), rd[e], exp_rd(e, address));
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      cycle();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic do_reset(input int n);
      address = 2'd0;
      reset_n = 1'b0;
      model_reset();
      #1;
      for (int e = 0; e < 3; e++) begin
         check_eq($sformatf("rst_rd%0d", e), rd[e], 32'd0);
         check_eq($sformatf("rst_irq%0d", e), {31'd0, irq_w[e]}, 32'd0);
      end
      repeat (n) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int  found;
      logic [31:0] exp_v;

      // Reset with all inputs high
      in_port = 8'hFF;
      do_reset(3);
      check_eq("data_after_release", rd[0], 32'd0);
      repeat (LAT_FILT - 1) cycle();
      check_eq("data_pre_filter", rd[0], 32'd0);
      cycle();
      check_eq("data_settled", rd[0], 32'hFF);
      address = 2'd3;
      cycle();
      check_eq("cap_rise_ff", rd[0], 32'hFF);
      check_eq("cap_fall_0", rd[1], 32'h00);
      check_eq("cap_any_ff", rd[2], 32'hFF);
      check_eq("irq_masked", {31'd0, irq_w[0]}, 32'd0);

      // Short pulse on bit 0
      bus_write(2'd3, 32'hFF);
      in_port = 8'h00;
      repeat (LAT_FILT + 5) cycle();
      bus_write(2'd3, 32'hFF);
      in_port[0] = 1'b1;
      repeat (10) cycle();
      in_port[0] = 1'b0;
      address = 2'd3;
      repeat (20) cycle();
      exp_v = DEB ? 32'd0 : 32'd1;
      check_eq("deb_rej_cap0", {31'd0, rd[0][0]}, exp_v);
      address = 2'd0;
      cycle();
      check_eq("deb_rej_data0", {31'd0, rd[0][0]}, 32'd0);

      // Interrupt flow on bit 2
      bus_write(2'd3, 32'hFF);
      bus_write(2'd2, 32'h04);
      in_port[2] = 1'b1;
      repeat (LAT_FILT + 2) cycle();
      check_eq("irq_on_rise", {31'd0, irq_w[0]}, 32'd1);
      bus_write(2'd3, 32'h04);
      check_eq("irq_cleared", {31'd0, irq_w[0]}, 32'd0);
      in_port[2] = 1'b0;
      repeat (LAT_FILT + 2) cycle();
      check_eq("irq_no_fall_cap", {31'd0, irq_w[0]}, 32'd0);
      check_eq("irq_fall_inst", {31'd0, irq_w[1]}, 32'd1);

      // Edge pulse on bit 5 coinciding with a clear of bit 5
      bus_write(2'd3, 32'hFF);
      bus_write(2'd2, 32'h20);
      in_port[5] = 1'b1;
      found = 0;
      for (int k = 0; k < 3 * DC; k++) begin
         if (m_filt[5] && !m_filtd[5]) begin
            bus_write(2'd3, 32'h20);
            found = 1;
            break;
         end
         cycle();
      end
      check_eq("collision_reached", found, 32'd1);
      check_eq("collision_cap5", {31'd0, rd[0][5]}, 32'd1);

      // Any-edge on bit 7, cleared between toggles
      bus_write(2'd3, 32'hFF);
      for (int t = 0; t < 2; t++) begin
         in_port[7] = ~in_port[7];
         address = 2'd3;
         repeat (LAT_FILT + 20) cycle();
         check_eq($sformatf("any_cap7_t%0d", t), {31'd0, rd[2][7]}, 32'd1);
         bus_write(2'd3, 32'h80);
         check_eq($sformatf("any_clr7_t%0d", t), {31'd0, rd[2][7]}, 32'd0);
      end

      // Bus decode
      address = 2'd0;
      cycle();
      exp_v = rd[0];
      bus_write(2'd0, 32'hFFFF_FFFF);
      check_eq("data_ro", rd[0], {24'd0, m_filt});
      bus_write(2'd2, 32'hFFFF_FFFF);
      check_eq("mask_ff", rd[0], 32'h0000_00FF);
      address = 2'd1;
      cycle();
      check_eq("addr1_zero", rd[0], 32'd0);
      bus_write(2'd1, 32'hFFFF_FFFF);
      check_eq("addr1_wr_zero", rd[2], 32'd0);
      check_eq("data_unchanged", {24'd0, m_filt}, exp_v);

      // Reset in the middle of a debounce run
      in_port = 8'hA5;
      repeat (8) cycle();
      do_reset(2);
      repeat (LAT_FILT + 5) cycle();

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         chipselect = 1'b0; write_n = 1'b1;
         address = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 24) == 0) in_port[$urandom_range(0, 7)] ^= 1'b1;
         if ($urandom_range(0, 9) == 0) begin
            chipselect = 1'b1;
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom;
         end
         cycle();
      end
      chipselect = 1'b0; write_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
